// File: rtl/ring_phase_monitor.sv
// ring_phase_monitor: decodes a rotating one-hot ring word into a phase index,
// counts revolutions, and flags non-one-hot words and illegal ring steps.
// Latency 1 clk from ring_in to every output; no backpressure (samples every clk).
// Optional build macro RING_MON_HOLD_EN: a repeated word in TRACK is a legal stall.
module ring_phase_monitor #(
   parameter int WIDTH = 4,
   parameter int REV_W = 8,
   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] ring_in,
   input  logic             clear,
   output logic [IDX_W-1:0] phase_idx,
   output logic             phase_valid,
   output logic             wrap,
   output logic [REV_W-1:0] rev_count,
   output logic             err_onehot,
   output logic             err_seq,
   output logic             err_any
);

   typedef enum logic {
      LOCK  = 1'b0,
      TRACK = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] last_q;
   logic [WIDTH-1:0] last_nxt;
   logic [IDX_W-1:0] phase_idx_nxt;
   logic             phase_valid_nxt;
   logic             wrap_nxt;
   logic [REV_W-1:0] rev_count_nxt;
   logic             err_onehot_nxt;
   logic             err_seq_nxt;

   // Per-sample classification of ring_in.
   logic             in_onehot;
   logic [IDX_W-1:0] in_enc;
   logic [WIDTH-1:0] succ_word;
   logic             is_succ;
   logic             is_hold;
   logic             new_err_onehot;
   logic             new_err_seq;

   // Count set bits and encode the set bit position; enc only matters for one-hot words.
   always_comb begin
      int unsigned ones;
      ones   = 0;
      in_enc = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (ring_in[i]) begin
            ones   = ones + 1;
            in_enc = IDX_W'(i);
         end
      end
      in_onehot = (ones == 1);
   end

   assign succ_word = {last_q[WIDTH-2:0], last_q[WIDTH-1]};
   assign is_succ   = (ring_in == succ_word);
   assign is_hold   = (ring_in == last_q);

   // Next-state / next-output decode; everything holds unless a branch says otherwise.
   always_comb begin
      state_nxt      = state;
      last_nxt       = last_q;
      phase_idx_nxt  = phase_idx;
      wrap_nxt       = 1'b0;
      new_err_onehot = 1'b0;
      new_err_seq    = 1'b0;

      case (state)
         LOCK: begin
            if (in_onehot) begin
               last_nxt      = ring_in;
               phase_idx_nxt = in_enc;
               state_nxt     = TRACK;
            end else begin
               new_err_onehot = 1'b1;
            end
         end
         TRACK: begin
            if (!in_onehot) begin
               // Drop out of lock; phase_idx and last_q keep the last good word.
               new_err_onehot = 1'b1;
               state_nxt      = LOCK;
            end else if (is_succ) begin
               last_nxt      = ring_in;
               phase_idx_nxt = in_enc;
               wrap_nxt      = last_q[WIDTH-1];
            end else if (is_hold) begin
`ifdef RING_MON_HOLD_EN
               // Upstream stalled: legal, nothing changes.
               new_err_seq = 1'b0;
`else
               // Upstream must advance every cycle; a repeat is a step error.
               new_err_seq = 1'b1;
`endif
            end else begin
               // Legal word, wrong position: flag and relock onto the new phase.
               new_err_seq   = 1'b1;
               last_nxt      = ring_in;
               phase_idx_nxt = in_enc;
            end
         end
         default: begin
            state_nxt = LOCK;
         end
      endcase

      phase_valid_nxt = (state_nxt == TRACK);

      // Clear beats the increment, but a same-cycle new error beats clear.
      if (clear) begin
         rev_count_nxt = '0;
      end else if (wrap_nxt) begin
         rev_count_nxt = rev_count + REV_W'(1);
      end else begin
         rev_count_nxt = rev_count;
      end
      err_onehot_nxt = (err_onehot & ~clear) | new_err_onehot;
      err_seq_nxt    = (err_seq & ~clear) | new_err_seq;
   end

   // State and output registers, cleared asynchronously at any point in a revolution.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= LOCK;
         last_q      <= '0;
         phase_idx   <= '0;
         phase_valid <= 1'b0;
         wrap        <= 1'b0;
         rev_count   <= '0;
         err_onehot  <= 1'b0;
         err_seq     <= 1'b0;
      end else begin
         state       <= state_nxt;
         last_q      <= last_nxt;
         phase_idx   <= phase_idx_nxt;
         phase_valid <= phase_valid_nxt;
         wrap        <= wrap_nxt;
         rev_count   <= rev_count_nxt;
         err_onehot  <= err_onehot_nxt;
         err_seq     <= err_seq_nxt;
      end
   end

   assign err_any = err_onehot | err_seq;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Scoreboard bench for ring_phase_monitor (WIDTH=4, REV_W=8).
// Inputs driven on negedge, outputs compared on the following negedge.
// Build with or without RING_MON_HOLD_EN; the reference model follows the same macro.
module tb_ring_phase_monitor;

   localparam int WIDTH = 4;
   localparam int REV_W = 8;
   localparam int IDX_W = 2;

   logic             clk;
   logic             reset;
   logic [WIDTH-1:0] ring_in;
   logic             clear;
   logic [IDX_W-1:0] phase_idx;
   logic             phase_valid;
   logic             wrap;
   logic [REV_W-1:0] rev_count;
   logic             err_onehot;
   logic             err_seq;
   logic             err_any;

   ring_phase_monitor #(.WIDTH(WIDTH), .REV_W(REV_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .ring_in    (ring_in),
      .clear      (clear),
      .phase_idx  (phase_idx),
      .phase_valid(phase_valid),
      .wrap       (wrap),
      .rev_count  (rev_count),
      .err_onehot (err_onehot),
      .err_seq    (err_seq),
      .err_any    (err_any)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [IDX_W-1:0] idx;
      logic             valid;
      logic             wrp;
      logic [REV_W-1:0] rev;
      logic             eo;
      logic             es;
   } exp_t;

   exp_t exp_q[$];

   int vectors;
   int miscompares;

   // Reference model state.
   bit               m_track;
   logic [WIDTH-1:0] m_last;
   logic [IDX_W-1:0] m_idx;
   logic             m_wrap;
   logic [REV_W-1:0] m_rev;
   logic             m_eo;
   logic             m_es;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [IDX_W-1:0] pos_of(input logic [WIDTH-1:0] w);
      case (w)
         4'b0001: return 2'd0;
         4'b0010: return 2'd1;
         4'b0100: return 2'd2;
         default: return 2'd3;
      endcase
   endfunction

   task automatic model_reset();
      m_track = 1'b0;
      m_last  = '0;
      m_idx   = '0;
      m_wrap  = 1'b0;
      m_rev   = '0;
      m_eo    = 1'b0;
      m_es    = 1'b0;
   endtask

   task automatic model_step(input logic [WIDTH-1:0] w, input logic clr);
      bit oh;
      bit n_eo;
      bit n_es;
      logic [WIDTH-1:0] nxt;
      oh   = ($countones(w) == 1);
      nxt  = {m_last[WIDTH-2:0], m_last[WIDTH-1]};
      n_eo = 1'b0;
      n_es = 1'b0;
      m_wrap = 1'b0;
      if (!m_track) begin
         if (oh) begin
            m_last = w; m_idx = pos_of(w); m_track = 1'b1;
         end else begin
            n_eo = 1'b1;
         end
      end else if (!oh) begin
         n_eo = 1'b1; m_track = 1'b0;
      end else if (w == nxt) begin
         m_wrap = m_last[WIDTH-1];
         m_last = w; m_idx = pos_of(w);
      end else if (w == m_last) begin
`ifndef RING_MON_HOLD_EN
         n_es = 1'b1;
`endif
      end else begin
         n_es = 1'b1; m_last = w; m_idx = pos_of(w);
      end
      if (clr) m_rev = '0;
      else if (m_wrap) m_rev = m_rev + 8'd1;
      m_eo = (clr ? 1'b0 : m_eo) | n_eo;
      m_es = (clr ? 1'b0 : m_es) | n_es;
   endtask

   // One sample: drive on negedge, predict, clock, then compare the popped prediction.
   task automatic step(input logic [WIDTH-1:0] w, input logic clr);
      exp_t e;
      exp_t got;
      ring_in = w;
      clear   = clr;
      model_step(w, clr);
      e.idx = m_idx; e.valid = m_track; e.wrp = m_wrap;
      e.rev = m_rev; e.eo = m_eo; e.es = m_es;
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      got = exp_q.pop_front();
      check_eq("phase_idx",   32'(phase_idx),   32'(got.idx));
      check_eq("phase_valid", 32'(phase_valid), 32'(got.valid));
      check_eq("wrap",        32'(wrap),        32'(got.wrp));
      check_eq("rev_count",   32'(rev_count),   32'(got.rev));
      check_eq("err_onehot",  32'(err_onehot),  32'(got.eo));
      check_eq("err_seq",     32'(err_seq),     32'(got.es));
      check_eq("err_any",     32'(err_any),     32'(got.eo | got.es));
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, ".phase_idx"},   32'(phase_idx),   32'd0);
      check_eq({tag, ".phase_valid"}, 32'(phase_valid), 32'd0);
      check_eq({tag, ".wrap"},        32'(wrap),        32'd0);
      check_eq({tag, ".rev_count"},   32'(rev_count),   32'd0);
      check_eq({tag, ".err_onehot"},  32'(err_onehot),  32'd0);
      check_eq({tag, ".err_seq"},     32'(err_seq),     32'd0);
      check_eq({tag, ".err_any"},     32'(err_any),     32'd0);
   endtask

   task automatic revolutions(input int n);
      for (int r = 0; r < n; r++) begin
         step(4'b0010, 1'b0);
         step(4'b0100, 1'b0);
         step(4'b1000, 1'b0);
         step(4'b0001, 1'b0);
      end
   endtask

   initial begin
      logic [WIDTH-1:0] w;
      vectors     = 0;
      miscompares = 0;
      ring_in     = '0;
      clear       = 1'b0;
      reset       = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b0;

      // 1: basic walk, one wrap on 1000 -> 0001.
      step(4'b0001, 1'b0);
      step(4'b0010, 1'b0);
      step(4'b0100, 1'b0);
      step(4'b1000, 1'b0);
      step(4'b0001, 1'b0);
      check_eq("t1.rev_count", 32'(rev_count), 32'd1);

      // 2: clear, then 256 revolutions wrap rev_count back to 0.
      step(4'b0010, 1'b1);
      step(4'b0100, 1'b0);
      step(4'b1000, 1'b0);
      step(4'b0001, 1'b0);
      revolutions(255);
      check_eq("t2.rev_wrap", 32'(rev_count), 32'd0);

      // 3: non-one-hot drops lock, relock without err_seq, then clear.
      step(4'b0010, 1'b0);
      step(4'b0110, 1'b0);
      step(4'b0100, 1'b0);
      check_eq("t3.idx", 32'(phase_idx), 32'd2);
      step(4'b1000, 1'b1);
      check_eq("t3.cleared", 32'(err_onehot), 32'd0);

      // 4: skip error, then clear colliding with a second skip.
      step(4'b0001, 1'b0);
      step(4'b0100, 1'b0);
      check_eq("t4.err_seq", 32'(err_seq), 32'd1);
      step(4'b0001, 1'b1);
      check_eq("t4.err_wins", 32'(err_seq), 32'd1);

      // 5: repeated word, outcome depends on the hold build option.
      step(4'b0010, 1'b1);
      step(4'b0010, 1'b0);
      check_eq("t5.idx", 32'(phase_idx), 32'd1);
`ifdef RING_MON_HOLD_EN
      check_eq("t5.hold_ok", 32'(err_seq), 32'd0);
`else
      check_eq("t5.hold_err", 32'(err_seq), 32'd1);
`endif

      // 6: rev_count=5 with err_seq set, reset asynchronously while at 0100.
      step(4'b0100, 1'b1);
      step(4'b1000, 1'b0);
      step(4'b0001, 1'b0);
      revolutions(4);
      step(4'b0100, 1'b0);
      check_eq("t6.rev5", 32'(rev_count), 32'd5);
      check_eq("t6.eseq", 32'(err_seq), 32'd1);
      #2 reset = 1'b1;
      #1 check_all_zero("async_reset");
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      step(4'b0001, 1'b0);
      check_eq("t6.relock_idx", 32'(phase_idx), 32'd0);
      check_eq("t6.relock_rev", 32'(rev_count), 32'd0);

      // Mixed traffic: mostly legal steps with occasional holds, skips and bad words.
      for (int k = 0; k < 300; k++) begin
         int sel;
         sel = $urandom_range(0, 9);
         if (sel < 6)       w = {m_last[WIDTH-2:0], m_last[WIDTH-1]};
         else if (sel == 6) w = m_last;
         else if (sel == 7) w = 4'b0001 << $urandom_range(0, 3);
         else               w = 4'($urandom_range(0, 15));
         step(w, ($urandom_range(0, 15) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
